regwr_arbiter: RTL and testbench
================================

// Module: regwr_arbiter
// PURPOSE
//  - Shares the single register-file write port (RegWr/rw/dataW) among NumReq writeback requesters.
//  - Requesters are, e.g., the ALU result, a load unit and an immediate path.
//  - Round-robin grant with a valid/ready handshake.
//  - One registered output stage drives the register file write port directly.
//  - pend_mask lets the decode stage see which register has a write in flight.
// PARAMETERS
//  AddressSize  3  register address width; register file depth = 2**AddressSize
//  WordSize     8  data word width
//  NumReq       2  number of requesters, legal range 1..8
// PORTS
//  clk        in   1                  single clock, all state on rising edge
//  rst        in   1                  asynchronous, active-high reset
//  wr_block   in   1                  1 = no grant this cycle (e.g. pipeline freeze)
//  req_valid  in   NumReq             per-requester write request
//  req_addr   in   NumReq*AddressSize packed; requester i at [i*AddressSize +: AddressSize]
//  req_data   in   NumReq*WordSize    packed; requester i at [i*WordSize +: WordSize]
//  req_ready  out  NumReq             one-hot or zero; accept = req_valid[i] & req_ready[i]
//  RegWr      out  1                  register file write enable (registered)
//  rw         out  AddressSize        register file write address (registered)
//  dataW      out  WordSize           register file write data (registered)
//  last_gnt   out  3                  index of the most recent accepted requester (registered)
//  pend_mask  out  2**AddressSize     one-hot of rw while RegWr=1, else 0
// BEHAVIOUR
//  Reset (async, immediate):
//  - RegWr=0, rw=0, dataW=0, last_gnt=0, round-robin pointer ptr=0.
//  - While rst=1, req_ready=0.
//  - A write captured in the output stage when reset asserts is discarded, never performed.
//  Grant (combinational from ptr, req_valid, wr_block):
//  - Winner = first i with req_valid[i]=1, scanning ptr, ptr+1, ..., NumReq-1, 0, ..., ptr-1.
//  - req_ready[winner]=1; every other ready bit is 0.
//  - No valid requests, or wr_block=1 -> req_ready=0.
//  - req_ready never depends on req_addr or req_data.
//  Handshake:
//  - A requester holds valid/addr/data stable until accepted.
//  - Deasserting valid before acceptance is allowed; the request is withdrawn with no side effect.
//  Output stage, at each posedge:
//  - Accept -> RegWr<=1, rw<=winner addr, dataW<=winner data, last_gnt<=winner,
//    ptr<=(winner+1) mod NumReq.
//  - No accept -> RegWr<=0; rw, dataW and last_gnt hold; ptr holds.
//  Latency and throughput:
//  - Accept in cycle N -> register file write at posedge N+1 (RegWr high during cycle N+1).
//  - One write per cycle; back-to-back accepts are legal.
//  Boundaries:
//  - ptr=NumReq-1 with winner NumReq-1 wraps ptr to 0.
//  - NumReq=1: ptr is always 0 and the block degenerates to a registered pass-through with wr_block.
//  - Same addr from two requesters in consecutive cycles: both writes are performed in grant order;
//    the last one wins in the register file.
//  - A requester that is never served waits at most NumReq-1 grants (starvation-free).
//  - pend_mask is derived from registered state only and is glitch-free.
// CONFIGURATION
//  REGWR_ZERO_LOCK_EN defined:
//  - Register 0 is hardwired to zero.
//  - A request with addr==0 is still granted and accepted, and the round-robin advances normally.
//  - The output stage loads RegWr<=0, so no write is performed and pend_mask stays 0.
//  - last_gnt still updates.
//  REGWR_ZERO_LOCK_EN undefined:
//  - addr 0 is written like any other register.
// TESTING
//  T1 reset: rst=1 mid-write (RegWr=1, rw=5) -> RegWr=0, rw=0, dataW=0, ptr=0 immediately;
//     req_ready=0 while rst=1.
//  T2 single: only req0 valid, addr=3, data=8'hA5 -> req_ready=2'b01 in the same cycle;
//     next cycle RegWr=1, rw=3, dataW=8'hA5, pend_mask=8'h08.
//  T3 fairness: NumReq=2, both requesters valid for 4 cycles -> grants 0,1,0,1;
//     RegWr high for 4 consecutive cycles; ptr wraps to 0.
//  T4 block: both valid, wr_block=1 for 3 cycles -> req_ready=0 and RegWr=0 throughout;
//     after release the grant goes to ptr's requester.
//  T5 withdraw: req1 valid then dropped before its grant -> no write at req1's addr;
//     ptr unchanged by req1.
//  T6 zero-lock: req0 addr=0, data=8'hFF -> with REGWR_ZERO_LOCK_EN: accepted, RegWr=0,
//     last_gnt=0; without it: RegWr=1, rw=0, dataW=8'hFF.

Source files
------------

// File: rtl/regwr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NumReq writeback requesters.
// Optional build macro REGWR_ZERO_LOCK_EN: register 0 is hardwired to zero (grants to addr 0 perform no write).
module regwr_arbiter #(
    parameter int AddressSize = 3,
    parameter int WordSize    = 8,
    parameter int NumReq      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_block,
    input  logic [NumReq-1:0]             req_valid,
    input  logic [NumReq*AddressSize-1:0] req_addr,
    input  logic [NumReq*WordSize-1:0]    req_data,
    output logic [NumReq-1:0]             req_ready,
    output logic                          RegWr,
    output logic [AddressSize-1:0]        rw,
    output logic [WordSize-1:0]           dataW,
    output logic [2:0]                    last_gnt,
    output logic [2**AddressSize-1:0]     pend_mask
);
    localparam int MaxReq = 8;
    localparam int Depth  = 2**AddressSize;

    // Requester lanes padded to the maximum count so the scan can index with 3 bits.
    logic [MaxReq-1:0]      valid_pad;
    logic [AddressSize-1:0] addr_arr [MaxReq];
    logic [WordSize-1:0]    data_arr [MaxReq];

    generate
        for (genvar gi = 0; gi < MaxReq; gi++) begin : g_lane
            if (gi < NumReq) begin : g_used
                assign valid_pad[gi] = req_valid[gi];
                assign addr_arr[gi]  = req_addr[gi*AddressSize +: AddressSize];
                assign data_arr[gi]  = req_data[gi*WordSize +: WordSize];
            end else begin : g_unused
                assign valid_pad[gi] = 1'b0;
                assign addr_arr[gi]  = '0;
                assign data_arr[gi]  = '0;
            end
        end
    endgenerate

    logic [2:0]             ptr_reg;
    logic [2:0]             ptr_next;
    logic [2:0]             winner;
    logic [3:0]             scan_idx;
    logic                   found;
    logic                   grant;
    logic                   write_en;
    logic [MaxReq-1:0]      ready_pad;
    logic [AddressSize-1:0] win_addr;
    logic [WordSize-1:0]    win_data;
    logic [Depth-1:0]       pend_next;

    // Scan ptr, ptr+1, ... wrapping at NumReq; first valid requester wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < NumReq; k++) begin
            scan_idx = {1'b0, ptr_reg} + 4'(k);
            if (scan_idx >= 4'(NumReq)) begin
                scan_idx = scan_idx - 4'(NumReq);
            end
            if (!found && valid_pad[scan_idx[2:0]]) begin
                found  = 1'b1;
                winner = scan_idx[2:0];
            end
        end
    end

    assign grant     = found & ~wr_block & ~rst;
    assign ready_pad = grant ? (8'b1 << winner) : '0;
    assign req_ready = ready_pad[NumReq-1:0];
    assign ptr_next  = (winner == 3'(NumReq - 1)) ? 3'd0 : winner + 3'd1;
    assign win_addr  = addr_arr[winner];
    assign win_data  = data_arr[winner];

`ifdef REGWR_ZERO_LOCK_EN
    assign write_en = (win_addr != '0);
`else
    assign write_en = 1'b1;
`endif

    assign pend_next = write_en ? (Depth'(1) << win_addr) : '0;

    // pend_mask is registered alongside RegWr/rw so decode sees a glitch-free mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWr     <= 1'b0;
            rw        <= '0;
            dataW     <= '0;
            last_gnt  <= '0;
            ptr_reg   <= '0;
            pend_mask <= '0;
        end else if (grant) begin
            RegWr     <= write_en;
            rw        <= win_addr;
            dataW     <= win_data;
            last_gnt  <= winner;
            ptr_reg   <= ptr_next;
            pend_mask <= pend_next;
        end else begin
            RegWr     <= 1'b0;
            pend_mask <= '0;
        end
    end
endmodule

// File: tb/tb_regwr_arbiter.sv
// Directed bench for regwr_arbiter (NumReq=2): reset, single write, fairness, block, withdraw, zero-lock.
`timescale 1ns/1ps
module tb_regwr_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_block;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [2:0] addr0, addr1;
    logic [7:0] data0, data1;
    logic       RegWr;
    logic [2:0] rw;
    logic [7:0] dataW;
    logic [2:0] last_gnt;
    logic [7:0] pend_mask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regwr_arbiter #(.AddressSize(3), .WordSize(8), .NumReq(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_block  (wr_block),
        .req_valid (req_valid),
        .req_addr  ({addr1, addr0}),
        .req_data  ({data1, data0}),
        .req_ready (req_ready),
        .RegWr     (RegWr),
        .rw        (rw),
        .dataW     (dataW),
        .last_gnt  (last_gnt),
        .pend_mask (pend_mask)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Advance one cycle; land just after the falling edge, away from the active edge.
    task automatic step;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_block = 1'b0; req_valid = 2'b00;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        step; step;
        check("rst_regwr", RegWr, 0);
        check("rst_rw", rw, 0);
        check("rst_dataw", dataW, 0);
        check("rst_last_gnt", last_gnt, 0);
        check("rst_pend", pend_mask, 0);
        req_valid = 2'b11; #1;
        check("rst_ready", req_ready, 0);
        req_valid = 2'b00; rst = 1'b0; #1;

        // T2 single request
        req_valid = 2'b01; addr0 = 3'd3; data0 = 8'hA5; #1;
        check("t2_ready", req_ready, 2'b01);
        step; req_valid = 2'b00; #1;
        check("t2_regwr", RegWr, 1);
        check("t2_rw", rw, 3);
        check("t2_dataw", dataW, 8'hA5);
        check("t2_pend", pend_mask, 8'h08);
        check("t2_last_gnt", last_gnt, 0);
        check("t2_ready_idle", req_ready, 0);

        // req1 alone, returns ptr to 0
        req_valid = 2'b10; addr1 = 3'd6; data1 = 8'h3C; #1;
        check("a_ready", req_ready, 2'b10);
        step; req_valid = 2'b00; #1;
        check("a_rw", rw, 6);
        check("a_dataw", dataW, 8'h3C);
        check("a_last_gnt", last_gnt, 1);
        check("a_pend", pend_mask, 8'h40);

        // T3 fairness: grants 0,1,0,1 with RegWr high 4 cycles
        req_valid = 2'b11; addr0 = 3'd1; data0 = 8'hA0; addr1 = 3'd2; data1 = 8'hB0; #1;
        check("t3_ready0", req_ready, 2'b01);
        step; data0 = 8'hA1; #1;
        check("t3_w0_regwr", RegWr, 1);
        check("t3_w0_rw", rw, 1);
        check("t3_w0_dataw", dataW, 8'hA0);
        check("t3_ready1", req_ready, 2'b10);
        step; data1 = 8'hB1; #1;
        check("t3_w1_regwr", RegWr, 1);
        check("t3_w1_rw", rw, 2);
        check("t3_w1_dataw", dataW, 8'hB0);
        check("t3_w1_gnt", last_gnt, 1);
        check("t3_ready2", req_ready, 2'b01);
        step; req_valid = 2'b10; #1;
        check("t3_w2_regwr", RegWr, 1);
        check("t3_w2_dataw", dataW, 8'hA1);
        check("t3_w2_gnt", last_gnt, 0);
        check("t3_ready3", req_ready, 2'b10);
        step; req_valid = 2'b00; #1;
        check("t3_w3_regwr", RegWr, 1);
        check("t3_w3_dataw", dataW, 8'hB1);
        check("t3_w3_gnt", last_gnt, 1);
        check("t3_w3_pend", pend_mask, 8'h04);
        step;
        check("t3_idle_regwr", RegWr, 0);
        check("t3_idle_rw", rw, 2);
        check("t3_idle_dataw", dataW, 8'hB1);
        check("t3_idle_pend", pend_mask, 0);

        // T4 wr_block for 3 cycles, then grant follows ptr (0)
        req_valid = 2'b11; addr0 = 3'd5; data0 = 8'h55; addr1 = 3'd6; data1 = 8'h66;
        wr_block = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_blk_ready", req_ready, 0);
            step;
            check("t4_blk_regwr", RegWr, 0);
        end
        wr_block = 1'b0; #1;
        check("t4_rel_ready", req_ready, 2'b01);
        step; req_valid = 2'b10; #1;
        check("t4_w0_regwr", RegWr, 1);
        check("t4_w0_rw", rw, 5);
        check("t4_w0_dataw", dataW, 8'h55);
        check("t4_ready1", req_ready, 2'b10);
        step; req_valid = 2'b00; #1;
        check("t4_w1_rw", rw, 6);
        check("t4_w1_dataw", dataW, 8'h66);
        check("t4_w1_gnt", last_gnt, 1);

        // T5 withdraw: move ptr to 1, then req1 appears and is dropped unserved
        req_valid = 2'b01; addr0 = 3'd4; data0 = 8'h44; #1;
        step; req_valid = 2'b00; #1;
        check("t5_pre_rw", rw, 4);
        wr_block = 1'b1; req_valid = 2'b10; addr1 = 3'd7; data1 = 8'h77; #1;
        check("t5_blk_ready", req_ready, 0);
        step; req_valid = 2'b00; wr_block = 1'b0; #1;
        check("t5_drop_ready", req_ready, 0);
        step;
        check("t5_no_write", RegWr, 0);
        check("t5_rw_hold", rw, 4);
        req_valid = 2'b11; addr0 = 3'd2; data0 = 8'h12; addr1 = 3'd3; data1 = 8'h33; #1;
        check("t5_ptr_ready", req_ready, 2'b10);
        step; req_valid = 2'b01; #1;
        check("t5_w1_rw", rw, 3);
        check("t5_w1_dataw", dataW, 8'h33);
        check("t5_w1_gnt", last_gnt, 1);
        check("t5_ready0", req_ready, 2'b01);
        step; req_valid = 2'b00; #1;
        check("t5_w0_rw", rw, 2);
        check("t5_w0_dataw", dataW, 8'h12);
        check("t5_w0_gnt", last_gnt, 0);

        // T6 write to register 0
        req_valid = 2'b01; addr0 = 3'd0; data0 = 8'hFF; #1;
        check("t6_ready", req_ready, 2'b01);
        step; req_valid = 2'b00; #1;
`ifdef REGWR_ZERO_LOCK_EN
        check("t6_regwr", RegWr, 0);
        check("t6_last_gnt", last_gnt, 0);
        check("t6_pend", pend_mask, 0);
`else
        check("t6_regwr", RegWr, 1);
        check("t6_rw", rw, 0);
        check("t6_dataw", dataW, 8'hFF);
        check("t6_pend", pend_mask, 8'h01);
`endif

        // T1 async reset mid-write with ptr=1
        req_valid = 2'b01; addr0 = 3'd5; data0 = 8'h5A; #1;
        step; req_valid = 2'b00; #1;
        check("t1_mid_regwr", RegWr, 1);
        check("t1_mid_rw", rw, 5);
        #2 rst = 1'b1; #1;
        check("t1_regwr", RegWr, 0);
        check("t1_rw", rw, 0);
        check("t1_dataw", dataW, 0);
        check("t1_last_gnt", last_gnt, 0);
        check("t1_pend", pend_mask, 0);
        req_valid = 2'b11; #1;
        check("t1_ready_rst", req_ready, 0);
        step;
        check("t1_hold_regwr", RegWr, 0);
        check("t1_hold_ready", req_ready, 0);
        rst = 1'b0; #1;
        check("t1_ptr_zero", req_ready, 2'b01);
        step; req_valid = 2'b00; #1;
        check("t1_post_regwr", RegWr, 1);
        check("t1_post_rw", rw, 5);
        check("t1_post_dataw", dataW, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
